// File: rtl/mc_muldiv_pkg.sv
// rtl/mc_muldiv_pkg.sv - op and state encodings shared by the mul/div unit and CPU control
package mc_muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10
  } state_e;

endpackage

// File: rtl/mc_muldiv_iter.sv
// rtl/mc_muldiv_iter.sv - one radix-2 shift-add or restoring shift-subtract step
module mc_muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   opnd_i,
  input  logic               div_i,
  output logic [2*WIDTH-1:0] acc_o,
  output logic               qbit_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  // acc holds {partial, multiplier} for MULT and {remainder, dividend/quotient} for DIV
  always_comb begin
    sum    = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, (acc_i[0] ? opnd_i : {WIDTH{1'b0}})};
    rem_sh = acc_i[2*WIDTH-1:WIDTH-1];
    diff   = rem_sh - {1'b0, opnd_i};
    qbit_o = 1'b0;
    acc_o  = {sum, acc_i[WIDTH-1:1]};
    if (div_i) begin
      qbit_o = ~diff[WIDTH];
      acc_o  = {(diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0]), acc_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mc_muldiv.sv
// rtl/mc_muldiv.sv - iterative multicycle signed/unsigned multiply/divide unit (HI/LO)
module mc_muldiv
  import mc_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             dz
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e               state_q;
  logic [CW-1:0]        cnt_q;
  logic [2*WIDTH-1:0]   acc_q, acc_d, iter_acc;
  logic [WIDTH-1:0]     opnd_q;
  logic                 div_q, sa_q, sb_q, dzint_q;
  logic                 busy_q, done_q, dz_q;
  logic [WIDTH-1:0]     hi_q, lo_q;
  logic                 qbit;

  logic                 signed_op, div_op, a_neg, b_neg;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     quo, rem, res_hi, res_lo;

  mc_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .acc_i  (acc_q),
    .opnd_i (opnd_q),
    .div_i  (div_q),
    .acc_o  (iter_acc),
    .qbit_o (qbit)
  );

  assign acc_d = iter_acc | {{(2*WIDTH-1){1'b0}}, qbit};

  always_comb begin
    signed_op = (op == OP_MULT) || (op == OP_DIV);
    div_op    = (op == OP_DIV) || (op == OP_DIVU);
    a_neg     = signed_op & a[WIDTH-1];
    b_neg     = signed_op & b[WIDTH-1];
    a_mag     = a_neg ? -a : a;
    b_mag     = b_neg ? -b : b;
  end

  // Most-negative / -1 needs no special case: its magnitude negates back to itself
  always_comb begin
    prod = (sa_q ^ sb_q) ? -acc_q : acc_q;
    quo  = (sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem  = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    if (dzint_q) begin
      res_hi = acc_q[WIDTH-1:0];
      res_lo = {WIDTH{1'b1}};
    end else if (div_q) begin
      res_hi = rem;
      res_lo = quo;
    end else begin
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      div_q   <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      dzint_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            dz_q   <= 1'b0;
            div_q  <= div_op;
            sa_q   <= a_neg;
            sb_q   <= b_neg;
            opnd_q <= b_mag;
            cnt_q  <= '0;
            // Divide by zero keeps the raw dividend so FIX can return it in hi
            if (div_op && (b == '0)) begin
              acc_q   <= {{WIDTH{1'b0}}, a};
              dzint_q <= 1'b1;
              state_q <= S_FIX;
            end else begin
              acc_q   <= {{WIDTH{1'b0}}, a_mag};
              dzint_q <= 1'b0;
              state_q <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (cancel) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST) state_q <= S_FIX;
          end
        end
        S_FIX: begin
          if (cancel) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            hi_q    <= res_hi;
            lo_q    <= res_lo;
            dz_q    <= dzint_q;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
  assign dz   = dz_q;

endmodule

// File: tb/tb_mc_muldiv.sv
// tb/tb_mc_muldiv.sv - directed self-checking bench for mc_muldiv (WIDTH=32 and WIDTH=8)
module tb_mc_muldiv;
  import mc_muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        clr, start, cancel;
  logic [1:0]  op;
  logic [31:0] a, b, hi, lo;
  logic        busy, done, dz;

  logic        clr8, start8, cancel8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8, hi8, lo8;
  logic        busy8, done8, dz8;

  int checks   = 0;
  int failures = 0;
  bit busy_bad;
  int lat, seen;

  always #5 clk = ~clk;

  mc_muldiv #(.WIDTH(32)) u32 (
    .clk(clk), .clr(clr), .start(start), .op(op), .a(a), .b(b), .cancel(cancel),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .dz(dz)
  );

  mc_muldiv #(.WIDTH(8)) u8 (
    .clk(clk), .clr(clr8), .start(start8), .op(op8), .a(a8), .b(b8), .cancel(cancel8),
    .busy(busy8), .done(done8), .hi(hi8), .lo(lo8), .dz(dz8)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int lat0, output int n);
    n = lat0;
    busy_bad = 1'b0;
    while (done !== 1'b1 && n < 200) begin
      if (busy !== 1'b1) busy_bad = 1'b1;
      tick();
      n++;
    end
    chk("done_seen", done, 1);
    chk("busy_clear_at_done", busy, 0);
  endtask

  task automatic run(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, output int n);
    op = o; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(0, n);
  endtask

  task automatic run8(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y, output int n);
    op8 = o; a8 = x; b8 = y; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    n = 0;
    while (done8 !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("done8_seen", done8, 1);
  endtask

  initial begin
    clr = 1'b1; start = 1'b0; cancel = 1'b0; op = OP_MULT; a = '0; b = '0;
    clr8 = 1'b1; start8 = 1'b0; cancel8 = 1'b0; op8 = OP_MULT; a8 = '0; b8 = '0;
    tick(); tick();
    clr = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dz", dz, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);

    run(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat);
    chk("multu_lat", lat, 33);
    chk("multu_busy_held", busy_bad, 0);
    chk("multu_hi", hi, 32'hFFFFFFFE);
    chk("multu_lo", lo, 32'h00000001);
    tick();
    chk("done_one_cycle", done, 0);
    chk("hi_held", hi, 32'hFFFFFFFE);

    run(OP_MULT, 32'hFFFFFFFD, 32'd7, lat);
    chk("mult_neg_hi", hi, 32'hFFFFFFFF);
    chk("mult_neg_lo", lo, 32'hFFFFFFEB);
    run(OP_DIV, 32'hFFFFFFF9, 32'd2, lat);
    chk("div_neg_lo", lo, 32'hFFFFFFFD);
    chk("div_neg_hi", hi, 32'hFFFFFFFF);
    run(OP_DIVU, 32'd7, 32'd2, lat);
    chk("divu_lo", lo, 3);
    chk("divu_hi", hi, 1);

    run(OP_DIV, 32'h80000000, 32'hFFFFFFFF, lat);
    chk("div_ovf_lat", lat, 33);
    chk("div_ovf_lo", lo, 32'h80000000);
    chk("div_ovf_hi", hi, 0);
    chk("div_ovf_dz", dz, 0);
    run(OP_DIV, 32'd5, 32'hFFFFFFFB, lat);
    chk("div_m5_lo", lo, 32'hFFFFFFFF);
    chk("div_m5_hi", hi, 0);

    run(OP_DIVU, 32'h1234, 32'd0, lat);
    chk("dz_lat", lat, 1);
    chk("dz_flag", dz, 1);
    chk("dz_lo", lo, 32'hFFFFFFFF);
    chk("dz_hi", hi, 32'h1234);

    op = OP_MULTU; a = 32'd3; b = 32'd4; start = 1'b1;
    tick();
    start = 1'b0;
    chk("dz_cleared_on_accept", dz, 0);
    chk("busy_on_accept", busy, 1);
    repeat (4) tick();
    op = OP_MULT; a = 32'd9; b = 32'd9; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(5, lat);
    chk("ignored_start_lat", lat, 33);
    chk("ignored_start_hi", hi, 0);
    chk("ignored_start_lo", lo, 12);

    op = OP_MULTU; a = 32'd5; b = 32'd6; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("cancel_busy", busy, 0);
    chk("cancel_done", done, 0);
    chk("cancel_hi", hi, 0);
    chk("cancel_lo", lo, 12);
    run(OP_DIVU, 32'd100, 32'd7, lat);
    chk("after_cancel_lat", lat, 33);
    chk("after_cancel_lo", lo, 14);
    chk("after_cancel_hi", hi, 2);

    op = OP_MULTU; a = 32'd2; b = 32'd3; start = 1'b1; cancel = 1'b1;
    tick();
    start = 1'b0; cancel = 1'b0;
    chk("idle_cancel_busy", busy, 1);
    wait_done(0, lat);
    chk("idle_cancel_lo", lo, 6);

    op = OP_DIV; a = 32'd100; b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (19) tick();
    clr = 1'b1; cancel = 1'b1; start = 1'b1;
    tick();
    clr = 1'b0; cancel = 1'b0; start = 1'b0;
    chk("clr_busy", busy, 0);
    chk("clr_done", done, 0);
    chk("clr_dz", dz, 0);
    chk("clr_hi", hi, 0);
    chk("clr_lo", lo, 0);
    seen = 0;
    repeat (40) begin
      tick();
      if (done === 1'b1) seen++;
    end
    chk("clr_no_done", seen, 0);
    run(OP_MULTU, 32'd2, 32'd3, lat);
    chk("after_clr_lat", lat, 33);
    chk("after_clr_lo", lo, 6);

    clr8 = 1'b0;
    chk("rst8_busy", busy8, 0);
    chk("rst8_lo", lo8, 0);
    run8(OP_MULT, 8'h80, 8'h80, lat);
    chk("mult8_lat", lat, 9);
    chk("mult8_hi", hi8, 8'h40);
    chk("mult8_lo", lo8, 8'h00);
    run8(OP_DIV, 8'h80, 8'h03, lat);
    chk("div8_lo", lo8, 8'hD6);
    chk("div8_hi", hi8, 8'hFE);
    run8(OP_DIV, 8'h80, 8'hFF, lat);
    chk("div8_ovf_lo", lo8, 8'h80);
    chk("div8_ovf_hi", hi8, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
